// File: rtl/frac_lut6_cfg_loader.sv
// Byte-serial configuration loader for one frac_lut6 tile: assembles a 10-byte frame
// in a shadow register, verifies its XOR checksum and commits it atomically to the LUT.
module frac_lut6_cfg_loader #(
    parameter logic [0:63] SRAM_RESET = 64'h0,
    parameter logic [0:0]  MODE_RESET = 1'b0
) (
    input  logic        prog_clk,
    input  logic        prog_reset_n,
    input  logic        cfg_start,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [0:63] sram,
    output logic [0:63] sram_inv,
    output logic [0:0]  mode,
    output logic [0:0]  mode_inv
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  acc_q, acc_d;
    logic [0:63] shadow_sram_q, shadow_sram_d;
    logic        shadow_mode_q, shadow_mode_d;
    logic        rsvd_bad_q, rsvd_bad_d;
    logic        chk_ok_q, chk_ok_d;
    logic [0:63] sram_q, sram_d;
    logic [0:0]  mode_q, mode_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [7:0]  data_rev;

    assign cfg_ready = (state_q == ST_LOAD) && !cfg_start;
    assign cfg_busy  = (state_q != ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;

    // sram is ascending [0:63], so bit j of byte k must land at position 8k+j,
    // i.e. the byte is written into an 8-bit ascending slice in reversed order.
    assign data_rev = {cfg_data[0], cfg_data[1], cfg_data[2], cfg_data[3],
                       cfg_data[4], cfg_data[5], cfg_data[6], cfg_data[7]};

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        shadow_sram_d = shadow_sram_q;
        shadow_mode_d = shadow_mode_q;
        rsvd_bad_d    = rsvd_bad_q;
        chk_ok_d      = chk_ok_q;
        sram_d        = sram_q;
        mode_d        = mode_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d    = ST_LOAD;
                    idx_d      = 4'd0;
                    acc_d      = 8'd0;
                    rsvd_bad_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    // Restart: the stale shadow is simply overwritten by the new frame.
                    idx_d      = 4'd0;
                    acc_d      = 8'd0;
                    rsvd_bad_d = 1'b0;
                end else if (accept) begin
                    if (idx_q <= 4'd8) begin
                        acc_d = acc_q ^ cfg_data;
                    end
                    if (idx_q < 4'd8) begin
                        shadow_sram_d[{idx_q[2:0], 3'b000} +: 8] = data_rev;
                    end
                    if (idx_q == 4'd8) begin
                        shadow_mode_d = cfg_data[0];
                        rsvd_bad_d    = |cfg_data[7:1];
                    end
                    if (idx_q == 4'd9) begin
                        chk_ok_d = (cfg_data == acc_q) && !rsvd_bad_q;
                        state_d  = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (chk_ok_q) begin
                    sram_d = shadow_sram_q;
                    mode_d = shadow_mode_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            acc_q         <= 8'd0;
            // NOTE: the shadow is an ordinary register bank, so it is reset like any other flop.
            shadow_sram_q <= '0;
            shadow_mode_q <= 1'b0;
            rsvd_bad_q    <= 1'b0;
            chk_ok_q      <= 1'b0;
            sram_q        <= SRAM_RESET;
            mode_q        <= MODE_RESET;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            shadow_sram_q <= shadow_sram_d;
            shadow_mode_q <= shadow_mode_d;
            rsvd_bad_q    <= rsvd_bad_d;
            chk_ok_q      <= chk_ok_d;
            sram_q        <= sram_d;
            mode_q        <= mode_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign sram     = sram_q;
    assign sram_inv = ~sram_q;
    assign mode     = mode_q;
    assign mode_inv = ~mode_q;

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Self-checking bench for frac_lut6_cfg_loader: directed frame table, hand-written
// restart/reset sequences and random frames checked against a frame-level model.
module tb_frac_lut6_cfg_loader;

    localparam logic [0:63] SRAM_RST = 64'hA5A5_0000_FFFF_1234;
    localparam logic [0:0]  MODE_RST = 1'b1;

    typedef logic [7:0] frame_t [10];

    typedef struct {
        frame_t b;
        bit     exp_ok;
        bit     gaps;
    } vec_t;

    logic        prog_clk;
    logic        prog_reset_n;
    logic        cfg_start;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [0:63] sram;
    logic [0:63] sram_inv;
    logic [0:0]  mode;
    logic [0:0]  mode_inv;

    frac_lut6_cfg_loader #(
        .SRAM_RESET(SRAM_RST),
        .MODE_RESET(MODE_RST)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .cfg_start   (cfg_start),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .sram        (sram),
        .sram_inv    (sram_inv),
        .mode        (mode),
        .mode_inv    (mode_inv)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int          vectors;
    int          miscompares;
    int          cyc;
    logic [0:63] model_sram;
    logic        model_mode;
    vec_t        tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Frame-level model: byte k bit j is truth-table entry 8k+j.
    function automatic logic [0:63] frame_sram(input frame_t b);
        logic [0:63] r;
        for (int i = 0; i < 64; i++) r[6'(i)] = b[4'(i / 8)][3'(i % 8)];
        return r;
    endfunction

    function automatic bit frame_ok(input frame_t b);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 0; k <= 8; k++) x = x ^ b[4'(k)];
        return (x == b[9]) && (b[8][7:1] == 7'd0);
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
        cyc++;
    endtask

    task automatic do_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cyc = 0;
        #1;
        check("ready_after_start", {63'd0, cfg_ready}, 64'd1);
    endtask

    task automatic send_bytes(input frame_t b, input int first, input int last, input bit gaps);
        int g;
        int budget;
        for (int k = first; k <= last; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                cfg_valid = 1'b0;
                cfg_data  = 8'($urandom);
                repeat (g) tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = b[4'(k)];
            #1;
            budget = 0;
            while (!cfg_ready && budget < 8) begin
                tick();
                budget++;
            end
            if (!cfg_ready) check("ready_timeout", {63'd0, cfg_ready}, 64'd1);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_commit(input frame_t b, input bit exp_ok, input bit gaps);
        check("busy_in_check", {63'd0, cfg_busy}, 64'd1);
        check("sram_hold_in_check", sram, model_sram);
        tick();
        check("done_pulse", {63'd0, cfg_done}, {63'd0, exp_ok});
        check("err_pulse", {63'd0, cfg_err}, {63'd0, !exp_ok});
        if (exp_ok) begin
            model_sram = frame_sram(b);
            model_mode = b[8][0];
        end
        check("sram", sram, model_sram);
        check("sram_inv", sram_inv, ~model_sram);
        check("mode", {63'd0, mode}, {63'd0, model_mode});
        check("mode_inv", {63'd0, mode_inv}, {63'd0, !model_mode});
        check("busy_after_commit", {63'd0, cfg_busy}, 64'd0);
        if (!gaps) check("commit_latency", 64'(cyc), 64'd11);
        tick();
        check("done_one_cycle", {62'd0, cfg_done, cfg_err}, 64'd0);
    endtask

    task automatic run_frame(input frame_t b, input bit exp_ok, input bit gaps);
        do_start();
        send_bytes(b, 0, 9, gaps);
        wait_commit(b, exp_ok, gaps);
    endtask

    initial begin
        frame_t f;
        logic [7:0] x;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = 8'd0;

        tbl[0].b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'hFE};
        tbl[0].exp_ok = 1'b1; tbl[0].gaps = 1'b0;
        tbl[1].b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'hFF};
        tbl[1].exp_ok = 1'b0; tbl[1].gaps = 1'b0;
        tbl[2].b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h03, 8'hFC};
        tbl[2].exp_ok = 1'b0; tbl[2].gaps = 1'b0;
        tbl[3].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h2A};
        tbl[3].exp_ok = 1'b1; tbl[3].gaps = 1'b0;
        tbl[4].b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'hFE};
        tbl[4].exp_ok = 1'b1; tbl[4].gaps = 1'b1;

        // Asynchronous reset: values must appear without any clock edge.
        prog_reset_n = 1'b1;
        #2 prog_reset_n = 1'b0;
        #1;
        model_sram = SRAM_RST;
        model_mode = MODE_RST;
        check("rst_sram", sram, SRAM_RST);
        check("rst_sram_inv", sram_inv, ~SRAM_RST);
        check("rst_mode", {63'd0, mode}, 64'd1);
        check("rst_mode_inv", {63'd0, mode_inv}, 64'd0);
        check("rst_handshake", {60'd0, cfg_ready, cfg_busy, cfg_done, cfg_err}, 64'd0);
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk) prog_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].b, tbl[i].exp_ok, tbl[i].gaps);
            if (i == 0) check("diag_pattern", sram, 64'h8040_2010_0804_0201);
        end

        // Restart after B4 with cfg_valid high in the same cycle: that byte is refused.
        f = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h99, 8'h66, 8'h11, 8'h22, 8'h01, 8'h00};
        x = 8'd0;
        for (int k = 0; k <= 8; k++) x = x ^ f[k];
        f[9] = x;
        do_start();
        send_bytes(tbl[3].b, 0, 4, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hEE;
        #1;
        check("ready_low_on_restart", {63'd0, cfg_ready}, 64'd0);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cyc = 0;
        send_bytes(f, 0, 9, 1'b0);
        wait_commit(f, 1'b1, 1'b1);

        // Asynchronous reset after B6 discards the frame immediately.
        do_start();
        send_bytes(tbl[3].b, 0, 6, 1'b0);
        #3 prog_reset_n = 1'b0;
        #1;
        model_sram = SRAM_RST;
        model_mode = MODE_RST;
        check("midrst_sram", sram, SRAM_RST);
        check("midrst_mode", {63'd0, mode}, 64'd1);
        check("midrst_busy_ready", {62'd0, cfg_busy, cfg_ready}, 64'd0);
        @(posedge prog_clk);
        @(negedge prog_clk) prog_reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            #1;
            check("idle_valid_ignored", {62'd0, cfg_ready, cfg_busy}, 64'd0);
            tick();
        end
        cfg_valid = 1'b0;
        run_frame(tbl[3].b, 1'b1, 1'b0);

        // Random frames against the frame-level model.
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 8; k++) f[k] = 8'($urandom);
            f[8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {7'd0, 1'($urandom)};
            x = 8'd0;
            for (int k = 0; k <= 8; k++) x = x ^ f[k];
            f[9] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : x;
            run_frame(f, frame_ok(f), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frac_lut6_cfg_loader.md
# frac_lut6_cfg_loader

Configuration loader for one `frac_lut6` tile. It accepts a byte-serial configuration frame over a valid/ready handshake and assembles the 64 truth-table bits plus the fracturing mode bit in a shadow register. It checks the frame's XOR checksum and then commits the contents atomically to the `sram`/`sram_inv`/`mode`/`mode_inv` inputs of the LUT. It sits between the programming bus and the LUT, so a LUT never sees a partially written or corrupted configuration.

## Interface
- `SRAM_RESET`, 64'h0: value of `sram` after reset.
- `MODE_RESET`, 1'b0: value of `mode` after reset.

Ports:
- `prog_clk`, input, 1: single clock. All state is on the rising edge.
- `prog_reset_n`, input, 1: asynchronous, active-low reset.
- `cfg_start`, input, 1: single-cycle pulse that opens a new frame.
- `cfg_data`, input, 8: frame byte.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_ready`, output, 1: loader accepts a byte this cycle.
- `cfg_busy`, output, 1: a frame is in progress.
- `cfg_done`, output, 1: one-cycle pulse when a commit succeeds.
- `cfg_err`, output, 1: one-cycle pulse when a frame is rejected.
- `sram`, output, [0:63]: LUT truth table, driven to `frac_lut6.sram`.
- `sram_inv`, output, [0:63]: always `~sram`.
- `mode`, output, [0:0]: fracturing mode bit.
- `mode_inv`, output, [0:0]: always `~mode`.

## Operation
- The frame is 10 bytes, B0..B9, counted by a 4-bit byte index `idx`.
  - B0..B7: bit j (LSB = 0) of Bk loads shadow bit sram[8k+j].
  - B8: bit 0 loads shadow mode. Bits 7:1 are reserved and must be 0.
  - B9: checksum. It must equal B0^B1^...^B8.
- The FSM has three states: IDLE, LOAD, CHECK.
  - IDLE → LOAD on `cfg_start`. This clears `idx` and the running XOR `acc`.
  - LOAD: each handshake (`cfg_valid && cfg_ready`) stores the byte. For idx ≤ 8 it also folds the byte into `acc`. It then increments `idx`. Accepting B9 (idx = 9) latches `chk_ok = (B9 == acc) && (B8[7:1] == 0)` and moves to CHECK.
  - LOAD + `cfg_start`: the frame restarts. `idx` and `acc` clear, the shadow is left as is (it gets overwritten), and the state stays LOAD.
  - CHECK → IDLE unconditionally after one cycle.
    - If `chk_ok`: `sram`/`mode` load from the shadow and `cfg_done` pulses.
    - Otherwise: the outputs hold and `cfg_err` pulses.
- `cfg_ready` = (state == LOAD) && !`cfg_start`. This is combinational from the state and `cfg_start`, not registered.
- `cfg_busy` = (state != IDLE).
- `cfg_start` during CHECK is ignored. A new frame needs a new `cfg_start` in IDLE.
- `cfg_valid` outside LOAD is ignored. No byte is consumed.
- `sram_inv`/`mode_inv` are the bitwise complements of the registered outputs, so they always track them.
- The 8-bit XOR has no width growth. `idx` never exceeds 9 and never wraps.

## Timing
- Reset (asynchronous, while `prog_reset_n` = 0):
  - state = IDLE, `idx` = 0, `acc` = 0, shadow = 0.
  - `sram` = `SRAM_RESET`, `sram_inv` = ~`SRAM_RESET`.
  - `mode` = `MODE_RESET`, `mode_inv` = ~`MODE_RESET`.
  - `cfg_ready`, `cfg_busy`, `cfg_done`, `cfg_err` = 0.
- Reset mid-frame discards the frame. The LUT outputs return to their reset values.
- `cfg_start` sampled at edge S: LOAD holds from S. `cfg_ready` is first high in the cycle after S.
- Throughput: one byte per cycle when `cfg_valid` is held high.
- B9 accepted at edge N:
  - CHECK is active during cycle N..N+1.
  - At edge N+1, `sram`/`mode` update (on a pass), `cfg_done` or `cfg_err` rises for exactly one cycle, and `cfg_busy` falls.
- Minimum frame: from the `cfg_start` edge to the commit edge is 11 cycles.
- Outputs never change except at a commit edge or on reset. There are no partial updates.

## Test plan
- Reset with `SRAM_RESET`=64'hA5A5_0000_FFFF_1234 and `MODE_RESET`=1 → `sram` = that value, `sram_inv` = its complement, `mode`=1, `mode_inv`=0, all handshake outputs 0.
- Back-to-back frame with B0..B7 = 8'h01,02,04,08,10,20,40,80, B8 = 8'h01, B9 = 8'hFE → `sram[0]`, `sram[9]`, `sram[18]`, ..., `sram[63]` = 1, all other bits 0, `mode`=1. `cfg_done` pulses 11 cycles after `cfg_start`.
- Same frame with B9 = 8'hFF → `cfg_err` pulse, `sram`/`mode` unchanged.
  - Repeat with B8 = 8'h03 and B9 = 8'hFC (correct XOR) → `cfg_err` because a reserved bit is set.
- `cfg_valid` toggled randomly, with gaps of 0-3 cycles → the bytes accepted are exactly the `cfg_valid && cfg_ready` cycles and the commit result matches the no-gap case.
- `cfg_start` reasserted after B4, in the same cycle as `cfg_valid` → that byte is not accepted (`cfg_ready`=0). A following full 10-byte frame commits correctly.
- `prog_reset_n` asserted asynchronously after B6 → reset values are immediate. A subsequent full frame commits normally. `cfg_valid` pulses in IDLE are ignored.
